// File: rtl/ext_pkg.sv
// Shared types for the ext_pipe immediate extender: ExtOp encoding, skid-buffer
// occupancy states and the jump-field helper.
package ext_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'b000,
        SIGN  = 3'b001,
        LUI   = 3'b010,
        SHAMT = 3'b011,
        LB    = 3'b100,
        LBU   = 3'b101,
        LH    = 3'b110,
        LHU   = 3'b111
    } ext_op_t;

    // Occupancy of the output/skid pair; the skid slot is only ever filled behind a held output.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b10
    } buf_state_t;

    localparam int IMM28_W = 28;

    function automatic logic [IMM28_W-1:0] jump_field(input logic [25:0] imm26);
        return {imm26, 2'b00};
    endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Upstream/downstream bundle for ext_pipe.
// Ext_Br exists only when EXT_BRANCH_OFF_EN is defined.
interface ext_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 32,
    parameter int BSEL_W = $clog2(WIDTH/8)
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       Imm16;
    logic [25:0]       Imm26;
    logic [2:0]        ExtOp;
    logic [WIDTH-1:0]  Din;
    logic [BSEL_W-1:0] ByteSel;
    logic [TAG_W-1:0]  TagIn;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  Ext_Imm;
    logic [27:0]       Ext_Imm28;
    logic [TAG_W-1:0]  TagOut;
`ifdef EXT_BRANCH_OFF_EN
    logic [WIDTH-1:0]  Ext_Br;
`endif

    modport master (
        output flush, in_valid, Imm16, Imm26, ExtOp, Din, ByteSel, TagIn, out_ready,
`ifdef EXT_BRANCH_OFF_EN
        input  Ext_Br,
`endif
        input  in_ready, out_valid, Ext_Imm, Ext_Imm28, TagOut
    );

    modport slave (
        input  flush, in_valid, Imm16, Imm26, ExtOp, Din, ByteSel, TagIn, out_ready,
`ifdef EXT_BRANCH_OFF_EN
        output Ext_Br,
`endif
        output in_ready, out_valid, Ext_Imm, Ext_Imm28, TagOut
    );

endinterface

// File: rtl/ext_core.sv
// Purely combinational extender: immediate modes and little-endian load-lane extension.
module ext_core
    import ext_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BSEL_W = $clog2(WIDTH/8)
) (
    input  logic [2:0]        ext_op,
    input  logic [15:0]       imm16,
    input  logic [WIDTH-1:0]  din,
    input  logic [BSEL_W-1:0] byte_sel,
    output logic [WIDTH-1:0]  result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half-word lanes drop the low select bit, so an odd offset picks the enclosing half.
    assign byte_lane = din[{byte_sel, 3'b000} +: 8];
    assign half_lane = din[{byte_sel[BSEL_W-1:1], 4'b0000} +: 16];

    always_comb begin
        result = '0;
        case (ext_op_t'(ext_op))
            ZERO:    result = WIDTH'(imm16);
            SIGN:    result = WIDTH'(signed'(imm16));
            LUI:     result = WIDTH'(signed'({imm16, 16'h0000}));
            SHAMT:   result = WIDTH'(imm16[10:6]);
            LB:      result = WIDTH'(signed'(byte_lane));
            LBU:     result = WIDTH'(byte_lane);
            LH:      result = WIDTH'(signed'(half_lane));
            LHU:     result = WIDTH'(half_lane);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer on the ID->EX boundary.
// Define EXT_BRANCH_OFF_EN to carry a branch offset (Ext_Br) with every entry.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 32,
    parameter int BSEL_W = $clog2(WIDTH/8)
) (
    input  logic     clk,
    input  logic     reset,
    ext_pipe_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0]   ext_imm;
        logic [IMM28_W-1:0] ext_imm28;
        logic [TAG_W-1:0]   tag;
`ifdef EXT_BRANCH_OFF_EN
        logic [WIDTH-1:0]   ext_br;
`endif
    } entry_t;

    buf_state_t       state;
    buf_state_t       state_next;
    entry_t           oreg;
    entry_t           sreg;
    entry_t           in_entry;
    logic [WIDTH-1:0] ext_result;
    logic             in_ready_int;
    logic             accept;
    logic             load_oreg_in;
    logic             load_oreg_skid;
    logic             load_sreg;

    ext_core #(
        .WIDTH  (WIDTH),
        .BSEL_W (BSEL_W)
    ) u_core (
        .ext_op   (bus.ExtOp),
        .imm16    (bus.Imm16),
        .din      (bus.Din),
        .byte_sel (bus.ByteSel),
        .result   (ext_result)
    );

    always_comb begin
        in_entry           = '0;
        in_entry.ext_imm   = ext_result;
        in_entry.ext_imm28 = jump_field(bus.Imm26);
        in_entry.tag       = bus.TagIn;
`ifdef EXT_BRANCH_OFF_EN
        in_entry.ext_br    = WIDTH'(signed'(bus.Imm16)) << 2;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= BUF_EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) state_next = BUF_ONE;
                BUF_ONE: begin
                    if (bus.out_ready) state_next = accept ? BUF_ONE : BUF_EMPTY;
                    else if (accept)   state_next = BUF_FULL;
                end
                BUF_FULL:  if (bus.out_ready) state_next = BUF_ONE;
                default:   state_next = BUF_EMPTY;
            endcase
        end
    end

    // in_ready depends only on registered occupancy and reset, never on out_ready.
    always_comb begin
        in_ready_int   = (state != BUF_FULL) && !reset;
        accept         = bus.in_valid && in_ready_int && !bus.flush;
        bus.in_ready   = in_ready_int;
        bus.out_valid  = (state != BUF_EMPTY);
        load_oreg_skid = (state == BUF_FULL) && bus.out_ready && !bus.flush;
        load_oreg_in   = accept && ((state == BUF_EMPTY) || bus.out_ready);
        load_sreg      = accept && (state == BUF_ONE) && !bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oreg <= '0;
            sreg <= '0;
        end else begin
            if (load_oreg_skid)    oreg <= sreg;
            else if (load_oreg_in) oreg <= in_entry;
            if (load_sreg)         sreg <= in_entry;
        end
    end

    assign bus.Ext_Imm   = oreg.ext_imm;
    assign bus.Ext_Imm28 = oreg.ext_imm28;
    assign bus.TagOut    = oreg.tag;
`ifdef EXT_BRANCH_OFF_EN
    assign bus.Ext_Br    = oreg.ext_br;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe (WIDTH=32): mode vector table, stall/flush/reset sequences and a
// randomized run against a FIFO reference model. Define EXT_BRANCH_OFF_EN to cover Ext_Br.
module tb_ext_pipe;
    import ext_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] din;
        logic [1:0]  bsel;
        logic [31:0] exp_imm;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [27:0] imm28;
        logic [31:0] tag;
        logic [31:0] br;
    } model_t;

    localparam int NVEC = 11;

    logic   clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[NVEC];
    model_t q[$];

    ext_pipe_if #(.WIDTH(32), .TAG_W(32)) bus();

    ext_pipe #(.WIDTH(32), .TAG_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return v[15] ? 32'(v) - 32'h0001_0000 : 32'(v);
    endfunction

    // Reference extension built from lane arithmetic rather than bit slicing.
    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [15:0] imm,
                                            input logic [31:0] din, input logic [1:0] bsel);
        logic [31:0] b;
        logic [31:0] h;
        b = (din >> (8 * int'(bsel))) & 32'hFF;
        h = (din >> (16 * (int'(bsel) / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return 32'(imm);
            3'd1:    return sext16(imm);
            3'd2:    return 32'(imm) << 16;
            3'd3:    return (32'(imm) >> 6) & 32'h1F;
            3'd4:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd5:    return b;
            3'd6:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            default: return h;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [15:0] imm16,
                                  input logic [25:0] imm26, input logic [31:0] din,
                                  input logic [1:0] bsel, input logic [31:0] tag);
        bus.in_valid = v;
        bus.ExtOp    = op;
        bus.Imm16    = imm16;
        bus.Imm26    = imm26;
        bus.Din      = din;
        bus.ByteSel  = bsel;
        bus.TagIn    = tag;
    endtask

    task automatic apply_tag(input int t);
        apply_stimulus(1'b1, SIGN, 16'hF000 | 16'(t), 26'(t), 32'h0, 2'd0, 32'(t));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{SIGN,  16'h8001, 26'h3FF_FFFF, 32'h80FF7F01, 2'd0, 32'hFFFF8001};
        vecs[1]  = '{ZERO,  16'h8001, 26'h000_0001, 32'h80FF7F01, 2'd0, 32'h00008001};
        vecs[2]  = '{LUI,   16'h8001, 26'h155_5555, 32'h80FF7F01, 2'd0, 32'h80010000};
        vecs[3]  = '{SHAMT, 16'h07C0, 26'h2AA_AAAA, 32'h80FF7F01, 2'd0, 32'h0000001F};
        vecs[4]  = '{LB,    16'h1234, 26'h000_0010, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF};
        vecs[5]  = '{LBU,   16'h1234, 26'h000_0020, 32'h80FF7F01, 2'd3, 32'h00000080};
        vecs[6]  = '{LH,    16'h1234, 26'h000_0030, 32'h80FF7F01, 2'd2, 32'hFFFF80FF};
        vecs[7]  = '{LHU,   16'h1234, 26'h000_0040, 32'h80FF7F01, 2'd0, 32'h00007F01};
        vecs[8]  = '{LH,    16'h1234, 26'h000_0050, 32'h80FF7F01, 2'd3, 32'hFFFF80FF};
        vecs[9]  = '{LB,    16'h1234, 26'h000_0060, 32'h80FF7F01, 2'd1, 32'h0000007F};
        vecs[10] = '{ZERO,  16'hFFFF, 26'h000_0070, 32'h80FF7F01, 2'd0, 32'h0000FFFF};

        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        apply_stimulus(1'b0, ZERO, 16'h0, 26'h0, 32'h0, 2'd0, 32'h0);
        tick();
        tick();
        check_output("reset_in_ready",  32'(bus.in_ready), 32'd0);
        check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset_ext_imm",   bus.Ext_Imm, 32'd0);
        check_output("reset_tag",       bus.TagOut, 32'd0);
        reset = 1'b0;
        #1;
        check_output("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(1'b1, vecs[i].op, vecs[i].imm16, vecs[i].imm26, vecs[i].din,
                           vecs[i].bsel, 32'(i + 100));
            tick();
            check_output($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("vec%0d_imm", i), bus.Ext_Imm, vecs[i].exp_imm);
            check_output($sformatf("vec%0d_model", i), bus.Ext_Imm,
                         ref_ext(vecs[i].op, vecs[i].imm16, vecs[i].din, vecs[i].bsel));
            check_output($sformatf("vec%0d_imm28", i), 32'(bus.Ext_Imm28),
                         32'({vecs[i].imm26, 2'b00}));
            check_output($sformatf("vec%0d_tag", i), bus.TagOut, 32'(i + 100));
`ifdef EXT_BRANCH_OFF_EN
            check_output($sformatf("vec%0d_br", i), bus.Ext_Br, sext16(vecs[i].imm16) << 2);
            if (vecs[i].imm16 == 16'hFFFF)
                check_output("br_all_ones", bus.Ext_Br, 32'hFFFFFFFC);
`endif
            bus.in_valid = 1'b0;
            tick();
            check_output($sformatf("vec%0d_drain", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: tags 1,2,3 against a stalled consumer.
        bus.out_ready = 1'b0;
        apply_tag(1);
        tick();
        check_output("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
        apply_tag(2);
        tick();
        check_output("bp_ready_after_2", 32'(bus.in_ready), 32'd0);
        check_output("bp_tag_hold_a", bus.TagOut, 32'd1);
        apply_tag(3);
        tick();
        check_output("bp_tag_hold_b", bus.TagOut, 32'd1);
        check_output("bp_imm_hold_b", bus.Ext_Imm, 32'hFFFFF001);
        tick();
        check_output("bp_tag_hold_c", bus.TagOut, 32'd1);
        check_output("bp_imm_hold_c", bus.Ext_Imm, 32'hFFFFF001);
        check_output("bp_ready_hold_c", 32'(bus.in_ready), 32'd0);
`ifdef EXT_BRANCH_OFF_EN
        check_output("bp_br_aligned", bus.Ext_Br, 32'hFFFFC004);
`endif
        bus.out_ready = 1'b1;
        tick();
        check_output("bp_second_tag", bus.TagOut, 32'd2);
        check_output("bp_second_imm", bus.Ext_Imm, 32'hFFFFF002);
        check_output("bp_ready_again", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("bp_third_tag", bus.TagOut, 32'd3);
        check_output("bp_third_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        check_output("bp_no_dup", 32'(bus.out_valid), 32'd0);

        // Flush with both registers full, then with in_ready high.
        bus.out_ready = 1'b0;
        apply_tag(10);
        tick();
        apply_tag(11);
        tick();
        apply_tag(12);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_output("flush_full_valid", 32'(bus.out_valid), 32'd0);
        check_output("flush_full_ready", 32'(bus.in_ready), 32'd1);
        apply_tag(20);
        tick();
        apply_tag(21);
        bus.flush = 1'b1;
        check_output("flush_ready_high", 32'(bus.in_ready), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_output("flush_one_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check_output("flush_input_gone", 32'(bus.out_valid), 32'd0);

        // Reset while stalled with both registers full.
        bus.out_ready = 1'b0;
        apply_tag(30);
        tick();
        apply_tag(31);
        tick();
        check_output("rst_stall_setup", 32'(bus.out_valid), 32'd1);
        apply_tag(32);
        reset = 1'b1;
        #1;
        check_output("rst_stall_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        check_output("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_stall_imm", bus.Ext_Imm, 32'd0);
        check_output("rst_stall_tag", bus.TagOut, 32'd0);
        check_output("rst_stall_imm28", 32'(bus.Ext_Imm28), 32'd0);
        check_output("rst_stall_ready", 32'(bus.in_ready), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_output("rst_stall_ready_after", 32'(bus.in_ready), 32'd1);
        tick();
        check_output("rst_stall_empty", 32'(bus.out_valid), 32'd0);

        // Randomized traffic against a 2-deep FIFO model.
        q.delete();
        for (int c = 0; c < 600; c++) begin
            logic        rv;
            logic        rdy;
            logic        fl;
            logic        exp_ready;
            logic [2:0]  op;
            logic [15:0] imm;
            logic [25:0] imm26;
            logic [31:0] din;
            logic [1:0]  bsel;
            logic [31:0] tag;
            rv    = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            fl    = ($urandom_range(0, 15) == 0);
            op    = 3'($urandom_range(0, 7));
            imm   = 16'($urandom);
            imm26 = 26'($urandom);
            din   = $urandom;
            bsel  = 2'($urandom_range(0, 3));
            tag   = $urandom;
            apply_stimulus(rv, op, imm, imm26, din, bsel, tag);
            bus.out_ready = rdy;
            bus.flush     = fl;
            check_output("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            check_output("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                check_output("rnd_imm", bus.Ext_Imm, q[0].imm);
                check_output("rnd_imm28", 32'(bus.Ext_Imm28), 32'(q[0].imm28));
                check_output("rnd_tag", bus.TagOut, q[0].tag);
`ifdef EXT_BRANCH_OFF_EN
                check_output("rnd_br", bus.Ext_Br, q[0].br);
`endif
            end
            if (fl) begin
                q.delete();
            end else begin
                exp_ready = (q.size() < 2);
                if (rdy && q.size() != 0) void'(q.pop_front());
                if (rv && exp_ready)
                    q.push_back('{ref_ext(op, imm, din, bsel), {imm26, 2'b00}, tag,
                                  sext16(imm) << 2});
            end
            tick();
        end
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
